// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, single-outstanding imem requests, prefetch FIFO.
// Optional zero-latency empty-FIFO bypass when IFU_BYPASS_EN is defined.
module instr_fetch_unit #(
    parameter int              ADDR_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_next, req_addr;
    logic [CW-1:0]     count, count_next;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [31:0]       fifo_instr [DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [DEPTH];

    logic ack_req, bypass, push, pop;

    assign ack_req = (state == REQ) && imem_ack;
`ifdef IFU_BYPASS_EN
    assign bypass = ack_req && (count == '0) && !redirect_valid && instr_ready;
`else
    assign bypass = 1'b0;
`endif
    assign push = ack_req && !redirect_valid && !bypass;
    assign pop  = (count != '0) && instr_ready && !redirect_valid;
    assign count_next = count + CW'(push) - CW'(pop);

    always_comb begin
        fetch_pc_next = fetch_pc;
        if (redirect_valid)
            fetch_pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
        else if (ack_req)
            fetch_pc_next = fetch_pc + ADDR_W'(4);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (redirect_valid || (count < CW'(DEPTH)))
                    next_state = REQ;
            end
            REQ: begin
                if (redirect_valid)
                    next_state = imem_ack ? REQ : DROP;
                else if (imem_ack)
                    next_state = (count_next < CW'(DEPTH)) ? REQ : IDLE;
            end
            DROP: begin
                if (imem_ack)
                    next_state = REQ;
            end
            default: next_state = IDLE;
        endcase
    end

    // req_addr only reloads when a (new) request is about to be issued, so it
    // is stable for the life of a REQ or DROP transaction.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= next_state;
            fetch_pc <= fetch_pc_next;
            if (next_state == REQ)
                req_addr <= fetch_pc_next;
            if (redirect_valid) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                count <= count_next;
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= fetch_pc;
        end
    end

    assign imem_req  = (state == REQ) || (state == DROP);
    assign imem_addr = req_addr;

`ifdef IFU_BYPASS_EN
    assign instr_valid = (count != '0) || bypass;
    assign instr       = bypass ? imem_rdata : fifo_instr[rd_ptr];
    assign instr_pc    = bypass ? fetch_pc   : fifo_pc[rd_ptr];
`else
    assign instr_valid = (count != '0);
    assign instr       = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench for instr_fetch_unit (DEPTH=4, RESET_PC=0).
module tb_instr_fetch_unit;
`ifdef IFU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'hC000_0000 | {8'h00, a[23:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0;
        @(negedge clock);
        #1;
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Ack one request with the word for the expected address.
    task automatic ack_at(input logic [31:0] a);
        @(negedge clock);
        imem_ack = 1'b1; imem_rdata = memw(a);
        #1;
        check("ack_addr", imem_addr, a);
        check("ack_req", {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: ack every 2nd cycle, ready held high
        instr_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            imem_ack = 1'b0;
            #1;
            check("t1_req", {31'b0, imem_req}, 32'd1);
            check("t1_addr", imem_addr, 32'(4 * k));
            if (k > 0) begin
                check("t1_valid_after", {31'b0, instr_valid}, {31'b0, !BYP});
                if (!BYP) begin
                    check("t1_pc", instr_pc, 32'(4 * (k - 1)));
                    check("t1_instr", instr, memw(32'(4 * (k - 1))));
                end
            end else begin
                check("t1_valid0", {31'b0, instr_valid}, 32'd0);
            end
            @(negedge clock);
            imem_ack = 1'b1; imem_rdata = memw(32'(4 * k));
            #1;
            check("t1_valid_ack", {31'b0, instr_valid}, {31'b0, BYP});
            if (BYP) begin
                check("t1_byp_pc", instr_pc, 32'(4 * k));
                check("t1_byp_instr", instr, memw(32'(4 * k)));
            end
        end

        // 2: stall until full, then one pop reopens fetch at 0x10
        instr_ready = 1'b0;
        do_reset();
        for (int j = 0; j < 4; j++) ack_at(32'(4 * j));
        @(negedge clock);
        imem_ack = 1'b0;
        #1;
        check("t2_req_full", {31'b0, imem_req}, 32'd0);
        check("t2_valid", {31'b0, instr_valid}, 32'd1);
        check("t2_head", instr_pc, 32'h0);
        @(negedge clock);
        instr_ready = 1'b1;
        #1;
        check("t2_req_still0", {31'b0, imem_req}, 32'd0);
        @(negedge clock);
        instr_ready = 1'b0;
        #1;
        check("t2_head_after_pop", instr_pc, 32'h4);
        check("t2_head_instr", instr, memw(32'h4));
        @(negedge clock);
        #1;
        check("t2_req_again", {31'b0, imem_req}, 32'd1);
        check("t2_addr", imem_addr, 32'h10);

        // 3: redirect while 0x8 pending -> DROP, then fetch 0x100
        do_reset();
        ack_at(32'h0);
        ack_at(32'h4);
        @(negedge clock);
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
        #1;
        check("t3_addr_pend", imem_addr, 32'h8);
        check("t3_valid_pre", {31'b0, instr_valid}, 32'd1);
        @(negedge clock);
        redirect_valid = 1'b0;
        #1;
        check("t3_flushed", {31'b0, instr_valid}, 32'd0);
        check("t3_drop_req", {31'b0, imem_req}, 32'd1);
        check("t3_drop_addr", imem_addr, 32'h8);
        ack_at(32'h8);
        @(negedge clock);
        imem_ack = 1'b0;
        #1;
        check("t3_discard", {31'b0, instr_valid}, 32'd0);
        check("t3_new_addr", imem_addr, 32'h100);

        // 4: redirect coincident with ack of 0xC
        do_reset();
        ack_at(32'h0);
        ack_at(32'h4);
        ack_at(32'h8);
        ack_at(32'hC);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clock);
        imem_ack = 1'b0; redirect_valid = 1'b0;
        #1;
        check("t4_flushed", {31'b0, instr_valid}, 32'd0);
        check("t4_addr", imem_addr, 32'h40);
        ack_at(32'h40);
        @(negedge clock);
        imem_ack = 1'b0;
        #1;
        check("t4_valid", {31'b0, instr_valid}, 32'd1);
        check("t4_pc", instr_pc, 32'h40);
        check("t4_instr", instr, memw(32'h40));

        // 5: count=3, simultaneous push and pop
        do_reset();
        ack_at(32'h0);
        ack_at(32'h4);
        ack_at(32'h8);
        ack_at(32'hC);
        instr_ready = 1'b1;
        #1;
        check("t5_head0", instr_pc, 32'h0);
        @(negedge clock);
        imem_ack = 1'b0; instr_ready = 1'b0;
        #1;
        check("t5_req", {31'b0, imem_req}, 32'd1);
        check("t5_addr", imem_addr, 32'h10);
        for (int j = 1; j < 4; j++) begin
            @(negedge clock);
            instr_ready = 1'b1;
            #1;
            check("t5_valid", {31'b0, instr_valid}, 32'd1);
            check("t5_order", instr_pc, 32'(4 * j));
            check("t5_instr", instr, memw(32'(4 * j)));
        end
        @(negedge clock);
        #1;
        check("t5_empty", {31'b0, instr_valid}, 32'd0);

        // 6: late ack after reset ignored, then empty-FIFO ack latency
        instr_ready = 1'b1;
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        imem_ack = 1'b0;
        #1;
        check("t6_late_ack", {31'b0, instr_valid}, 32'd0);
        check("t6_addr0", imem_addr, 32'h0);
        ack_at(32'h0);
        check("t6_valid_ack", {31'b0, instr_valid}, {31'b0, BYP});
        @(negedge clock);
        imem_ack = 1'b0;
        #1;
        check("t6_valid_next", {31'b0, instr_valid}, {31'b0, !BYP});
        check("t6_addr_next", imem_addr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
